// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module : ula_pkg
// Desc   : Shared opcodes, FSM state encoding and default width for the
//          arbitrated ALU.
// Rev    : 1.0
// ============================================================================
package ula_pkg;

    localparam int ULA_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ula_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : ula_arbiter_if
// Desc   : Two-requester ALU request bus; master = requesters, slave = arbiter.
// Rev    : 1.0
// ============================================================================
interface ula_arbiter_if #(
    parameter int WIDTH = ula_pkg::ULA_WIDTH
) ();
    import ula_pkg::*;

    logic             req0;
    logic [2:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             err;
    logic             busy;
    logic             owner;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  ack0, ack1, result, zero, carry, err, busy, owner
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output ack0, ack1, result, zero, carry, err, busy, owner
    );

endinterface
`default_nettype wire

// File: rtl/ula_core.sv
`default_nettype none
// ============================================================================
// Module : ula_core
// Desc   : Purely combinational ALU datapath; holds no state.
// Rev    : 1.0
// ============================================================================
module ula_core #(
    parameter int WIDTH = ula_pkg::ULA_WIDTH
) (
    input  wire logic [2:0]       op_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic      [WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  err_o
);
    import ula_pkg::*;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit is the ADD carry-out / SUB borrow (set exactly when a < b)
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        err_o    = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = diff[WIDTH-1:0];
                carry_o  = diff[WIDTH];
            end
            OP_OR:   result_o = a_i | b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_NOT:  result_o = ~a_i;
            OP_SLT:  result_o = WIDTH'(a_i < b_i);
            default: err_o    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ula_arbiter
// Desc   : Round-robin arbiter sharing one ALU between two requesters,
//          three cycles per operation, all outputs registered.
// Rev    : 1.0
// ============================================================================
module ula_arbiter #(
    parameter int WIDTH = ula_pkg::ULA_WIDTH
) (
    input wire logic     clk,
    input wire logic     clr,
    ula_arbiter_if.slave bus
);
    import ula_pkg::*;

    state_e           state_q;
    logic             last_q;
    logic             owner_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             err_q;
    logic             busy_q;
    logic             ack0_q;
    logic             ack1_q;

    logic             grant_d;
    logic             winner_d;
    logic [WIDTH-1:0] alu_result_d;
    logic             alu_carry_d;
    logic             alu_err_d;

    // On a tie the requester that was not served last wins
    always_comb begin
        grant_d  = bus.req0 | bus.req1;
        winner_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    end

    ula_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result_d),
        .carry_o  (alu_carry_d),
        .err_o    (alu_err_d)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner_q <= winner_d;
                        last_q  <= winner_d;
                        op_q    <= winner_d ? bus.op1 : bus.op0;
                        a_q     <= winner_d ? bus.a1  : bus.a0;
                        b_q     <= winner_d ? bus.b1  : bus.b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result_d;
                    zero_q   <= (alu_result_d == '0);
                    carry_q  <= alu_carry_d;
                    err_q    <= alu_err_d;
                    ack0_q   <= ~owner_q;
                    ack1_q   <= owner_q;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.owner  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ula_arbiter
// Desc   : Self-checking bench for ula_arbiter against an arithmetic ALU model.
// Rev    : 1.0
// ============================================================================
module tb_ula_arbiter;

    localparam int W = 8;

    logic clk = 1'b0;
    logic clr;
    int   total  = 0;
    int   bad    = 0;
    int   last_g = 1;

    logic [2:0]   cop [2];
    logic [W-1:0] ca  [2];
    logic [W-1:0] cb  [2];
    int           got;
    int           n;
    int           exp_w;
    int           acks;

    ula_arbiter_if #(.WIDTH(W)) bus ();

    ula_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Returns {err, carry, result} from plain integer arithmetic
    function automatic logic [W+1:0] model(input int op, input int a, input int b);
        int m = 1 << W;
        int r = 0;
        bit c = 1'b0;
        bit e = 1'b0;
        case (op)
            0: begin r = (a + b) % m; c = ((a + b) >= m); end
            1: begin r = (a - b + m) % m; c = (a < b); end
            2: r = a | b;
            3: r = a & b;
            4: r = (m - 1) - a;
            5: r = (a < b) ? 1 : 0;
            default: e = 1'b1;
        endcase
        return {e, c, W'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int who, input logic rq, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (who == 0) begin
            bus.req0 = rq; bus.op0 = op; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = rq; bus.op1 = op; bus.a1 = a; bus.b1 = b;
        end
    endtask

    task automatic wait_ack(output int who, output int cyc);
        who = -1;
        cyc = 0;
        while (who < 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0) who = 0;
            else if (bus.ack1) who = 1;
        end
        chk("ack_seen", (who >= 0), 1);
    endtask

    task automatic check_result(input int who, input int seen, input logic [W+1:0] exp);
        chk("ack_owner", seen, who);
        chk("ack_excl", bus.ack0 & bus.ack1, 0);
        chk("owner", bus.owner, who);
        chk("result", bus.result, exp[W-1:0]);
        chk("zero", bus.zero, (exp[W-1:0] == 0));
        chk("carry", bus.carry, exp[W]);
        chk("err", bus.err, exp[W+1]);
    endtask

    task automatic do_op(input int who, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit alter);
        logic [W+1:0] exp;
        int seen;
        int cyc;
        exp = model(op, a, b);
        @(posedge clk); #1;
        drive(who, 1'b1, op, a, b);
        @(negedge clk);
        @(negedge clk);
        chk("busy_exec", bus.busy, 1);
        chk("no_early_ack", bus.ack0 | bus.ack1, 0);
        if (alter) drive(who, 1'b1, op, ~a, ~b);
        wait_ack(seen, cyc);
        chk("latency", cyc + 2, 3);
        check_result(who, seen, exp);
        last_g = who;
        @(posedge clk); #1;
        drive(who, 1'b0, op, a, b);
        @(negedge clk);
        chk("ack_low", bus.ack0 | bus.ack1, 0);
        chk("idle_busy", bus.busy, 0);
        chk("hold_result", bus.result, exp[W-1:0]);
    endtask

    initial begin
        clr = 1'b1;
        drive(0, 1'b0, 3'd0, '0, '0);
        drive(1, 1'b0, 3'd0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_owner", bus.owner, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_acks", {bus.ack0, bus.ack1}, 0);
        chk("rst_err_carry", {bus.err, bus.carry}, 0);
        clr = 1'b0;

        // Contention: both requesters keep asking; service must alternate from 0
        for (int w = 0; w < 2; w++) begin
            cop[w] = 3'($urandom_range(0, 5));
            ca[w]  = W'($urandom);
            cb[w]  = W'($urandom);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, cop[0], ca[0], cb[0]);
        drive(1, 1'b1, cop[1], ca[1], cb[1]);
        for (int k = 0; k < 6; k++) begin
            exp_w = 1 - last_g;
            wait_ack(got, n);
            chk("rr_order", got, exp_w);
            check_result(exp_w, got, model(cop[exp_w], ca[exp_w], cb[exp_w]));
            last_g = exp_w;
            @(posedge clk); #1;
            drive(exp_w, 1'b0, cop[exp_w], ca[exp_w], cb[exp_w]);
            @(posedge clk); #1;
            cop[exp_w] = 3'($urandom_range(0, 7));
            ca[exp_w]  = W'($urandom);
            cb[exp_w]  = W'($urandom);
            drive(exp_w, 1'b1, cop[exp_w], ca[exp_w], cb[exp_w]);
        end
        exp_w = 1 - last_g;
        wait_ack(got, n);
        chk("rr_order_last", got, exp_w);
        check_result(exp_w, got, model(cop[exp_w], ca[exp_w], cb[exp_w]));
        last_g = exp_w;
        @(posedge clk); #1;
        drive(0, 1'b0, cop[0], ca[0], cb[0]);
        drive(1, 1'b0, cop[1], ca[1], cb[1]);
        @(negedge clk);

        // Directed boundaries
        do_op(0, 3'd0, 8'd200, 8'd100, 1'b0);
        do_op(1, 3'd1, 8'd5,   8'd5,   1'b0);
        do_op(0, 3'd1, 8'd3,   8'd4,   1'b0);
        do_op(1, 3'd5, 8'd3,   8'd4,   1'b0);
        do_op(0, 3'd5, 8'd4,   8'd3,   1'b0);
        do_op(0, 3'd4, 8'h0F,  8'hFF,  1'b0);
        do_op(1, 3'd7, 8'h12,  8'h34,  1'b0);
        do_op(0, 3'd0, 8'd10,  8'd20,  1'b1);

        for (int i = 0; i < 30; i++) begin
            do_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        // Abort mid-EXEC with an async clear
        do_op(1, 3'd0, 8'd1, 8'd1, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b1, 3'd0, 8'd200, 8'd100);
        @(negedge clk);
        @(negedge clk);
        chk("busy_pre_clr", bus.busy, 1);
        clr = 1'b1;
        drive(1, 1'b0, 3'd0, 8'd200, 8'd100);
        #1;
        chk("clr_busy", bus.busy, 0);
        chk("clr_result", bus.result, 0);
        chk("clr_zero", bus.zero, 1);
        chk("clr_owner", bus.owner, 0);
        chk("clr_acks", {bus.ack0, bus.ack1}, 0);
        last_g = 1;
        @(negedge clk);
        clr = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks++;
        end
        chk("no_ack_after_clr", acks, 0);
        do_op(1, 3'd3, 8'hF0, 8'h3C, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width.
REQ-002 Port clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port clr  in  1  reset, asynchronous, active-high.
REQ-004 Port req0  in  1  requester 0 operation request, held high until ack0.
REQ-005 Port op0  in  3  requester 0 opcode.
REQ-006 Port a0, b0  in  WIDTH each  requester 0 operands.
REQ-007 Port req1, op1, a1, b1  in  1/3/WIDTH/WIDTH  requester 1 equivalents.
REQ-008 Port ack0, ack1  out  1 each  one-cycle completion pulse to the owning requester.
REQ-009 Port result  out  WIDTH  registered ALU result, valid while the ack is high.
REQ-010 Port zero  out  1  result == 0.
REQ-011 Port carry  out  1  ADD carry-out / SUB borrow, 0 for other ops.
REQ-012 Port err  out  1  opcode was invalid (6 or 7).
REQ-013 Port busy  out  1  high in EXEC and DONE.
REQ-014 Port owner  out  1  index of the requester currently granted (last granted when idle).

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 NOT (a only, b ignored), 5 SLT.
REQ-016 ADD/SUB SHALL wrap modulo 2^WIDTH; carry = bit WIDTH of a+b for ADD, (a<b) for SUB.
REQ-017 SLT SHALL be an unsigned compare: result = 1 if a<b else 0.
REQ-018 Invalid opcode SHALL give result 0, zero 1, carry 0, err 1; still acked.
REQ-019 FSM states SHALL be IDLE, EXEC, DONE.
REQ-020 IDLE: if any req high, grant winner, latch its op/a/b, set owner, go EXEC; else stay.
REQ-021 EXEC: compute from latched values, register result/zero/carry/err, go DONE (unconditional).
REQ-022 DONE: assert ack of owner only, go IDLE (unconditional).
REQ-023 Latency SHALL be: grant edge E, ack high in cycle after edge E+1, i.e. 3 cycles per operation, one op in flight.
REQ-024 Arbitration SHALL be round-robin: single req wins; both high -> the requester not granted last wins.
REQ-025 Requester inputs SHALL be ignored outside IDLE; changing operands after grant has no effect.
REQ-026 Requester SHALL drop req in the cycle after its ack; a req still high in IDLE is a new request.
REQ-027 result/zero/carry/err SHALL hold their value until the next EXEC completes.
REQ-028 ack0 and ack1 SHALL never be high simultaneously.

Reset
REQ-029 clr high SHALL immediately force state IDLE, ack0/ack1/busy/err/carry 0, result 0, zero 1, owner 0, last-granted pointer = 1 (requester 0 wins first tie).
REQ-030 clr during EXEC or DONE SHALL abort the operation; no ack is issued afterwards.
REQ-031 First grant SHALL be possible on the first rising edge after clr falls.

Structure
REQ-032 Shared package ula_pkg SHALL hold opcode constants, FSM state encoding, and default WIDTH.
REQ-033 The combinational compute SHALL be one sub-module ula_core (op, a, b -> result, carry, err); the arbiter owns all registers.

Verification
REQ-034 Reset: clr pulse mid-EXEC -> busy 0, result 0, zero 1, no ack within following 5 cycles.
REQ-035 Single ADD: req0, op0=0, a0=200, b0=100 -> ack0 after 3 cycles, result 44, carry 1, zero 0.
REQ-036 SUB/SLT boundaries: a=5,b=5 SUB -> 0, zero 1, carry 0; a=3,b=4 SUB -> 255, carry 1; SLT 3,4 -> 1; SLT 4,3 -> 0.
REQ-037 Contention: req0 and req1 held high continuously, each dropping/reasserting per REQ-026 -> acks alternate 0,1,0,1 starting with 0.
REQ-038 NOT and invalid: op0=4, a0=0x0F, b0=0xFF -> 0xF0; op1=7 -> result 0, err 1, ack1 asserted.
REQ-039 Operand change after grant: a0 altered during EXEC -> result reflects values latched at grant.
